rsa_modexp_lsb_param: RTL
=========================

// Module: rsa_modexp_lsb_param
// PURPOSE
//  Parametrised LSB-first modular exponentiator: result = M^E mod N, WIDTH-bit operands, radix-2 Montgomery.
//  Next generation of the RSA datapath. Integrates Montgomery pre-conversion, scans E only up to its MSB,
//  and reports operand errors. Adds a start/busy/done handshake. Sits under the RSA top beside the I/O wrapper.
// PARAMETERS
//  WIDTH  256  operand width in bits (>=4)
//  CNT_W  $clog2(WIDTH)+1  width of bit/iteration counters (derived; do not override)
// PORTS
//  clk     in   1      clock, all flops on rising edge
//  rst     in   1      reset, asynchronous, active-high
//  start   in   1      1-cycle request; sampled only in IDLE
//  M       in   WIDTH  base; captured on accepted start
//  E       in   WIDTH  exponent; captured on accepted start
//  N       in   WIDTH  modulus; captured on accepted start
//  busy    out  1      high from cycle after accepted start until the done cycle, inclusive
//  done    out  1      1-cycle pulse; result/err valid from this cycle, held until next accepted start
//  err     out  1      operand error: N even, or M>=N
//  result  out  WIDTH  M^E mod N (0 when err)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, err=0, result=0, all internal regs 0. Reset mid-operation aborts, no done.
//  start while busy: ignored, no effect on captured operands.
//  FSM: IDLE -start-> SCAN -> (err ? FIN : PRE) ; PRE -WIDTH cycles-> (k==0 ? FIN : EXP) ; EXP -last bit-> FIN ; FIN -> IDLE.
//  SCAN (1 cycle): err = ~N[0] | (M>=N); k = index of MSB of E plus 1 (k=0 if E==0), via priority encoder.
//  PRE: T=M; WIDTH iterations T=2T, if T>=N then T-=N (WIDTH+1-bit intermediate). Yields T=M*2^WIDTH mod N.
//    S=1 (plain domain).
//  EXP, bit j=0..k-1: start both mont_mul instances together: S'=MM(S,T) used only if E[j]=1, else S held;
//    T'=MM(T,T). Each bit costs WIDTH+2 cycles: 1 issue + WIDTH+1 mont_mul.
//  MM(A,B)=A*B*2^-WIDTH mod N, so S remains plain and the final S equals M^E mod N with no post-conversion.
//  FIN (1 cycle): done=1, busy=1, result=S (S=1 mod N when k=0; hence 0 if N==1), or 0 with err=1.
//  Latency from start-sample cycle to done: L = 3 + WIDTH + k*(WIDTH+2); error case L = 2.
//  Arithmetic: mont_mul internal accumulator WIDTH+2 bits; single conditional final subtract gives output < N.
//    Inputs < N are required; guaranteed by the err check.
//  Counter wrap: bit counter j compared against k with CNT_W bits, so k=WIDTH (E MSB set) terminates correctly.
// STRUCTURE
//  rsa_pkg: state encoding (IDLE,SCAN,PRE,EXP,FIN), default WIDTH, mont_mul latency constant MM_LAT=WIDTH+1.
//  Sub-module mont_mul (params WIDTH): in clk,rst,start,A,B,N; out done pulse, V.
//    Fixed MM_LAT cycles from start to done. Two instances: S-path and T-path.
//  Top file: FSM, operand capture, PRE shift-subtract loop, MSB encoder, counters, output regs.
// TESTING (WIDTH=8 unless noted)
//  M=5,E=3,N=13 -> result=8, err=0, done exactly 31 cycles after start, busy high throughout.
//  M=7,E=0,N=11 -> result=1 at L=11; M=3,E=0,N=1 -> result=0.
//  N=12 (even) or M=20,N=13 -> err=1, result=0, done at L=2; next valid start clears err.
//  E=8'hFF,M=2,N=255 -> result=2^255 mod 255=128, L=3+8+8*10=91 (k=WIDTH wrap case).
//  start pulsed again mid-EXP, then rst asserted mid-EXP -> second start ignored; after rst all outputs 0, no done.
//  WIDTH=256: random odd N, M<N, E up to 256 bits vs. reference model pow(M,E,N); check result and L.

Source files
------------

// File: rtl/rsa_modexp_lsb_param_pkg.sv
// Shared definitions for the LSB-first Montgomery modular exponentiator.
//   state_t       : controller state encoding
//   DEFAULT_WIDTH : default operand width
//   mm_lat()      : mont_mul latency (start to done) for a given width
package rsa_modexp_lsb_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        PRE,
        EXP,
        FIN
    } state_t;

    localparam int DEFAULT_WIDTH = 256;

    function automatic int mm_lat(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/rsa_modexp_lsb_param_if.sv
// Request/response bundle of the modular exponentiator.
//   start          : 1-cycle request
//   M, E, N        : base, exponent, modulus (captured on accepted start)
//   busy, done     : operation in progress / 1-cycle completion pulse
//   err, result    : operand error flag / M^E mod N
// master: requester side, slave: exponentiator side.
interface rsa_modexp_lsb_param_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] N;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (output start, M, E, N, input busy, done, err, result);
    modport slave  (input start, M, E, N, output busy, done, err, result);
endinterface

// File: rtl/rsa_modexp_lsb_param_mont_mul.sv
// Radix-2 Montgomery multiplier: V = A*B*2^-WIDTH mod N (A, B < N, N odd).
//   clk, rst : clock, asynchronous active-high reset
//   start    : load operands and begin
//   A, B, N  : operands
//   done     : high for one cycle exactly mm_lat(WIDTH) cycles after start
//   V        : result, valid while done is high
module mont_mul
    import rsa_modexp_lsb_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] N,
    output logic             done,
    output logic [WIDTH-1:0] V
);
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int MM_LAT = mm_lat(WIDTH);

    logic [WIDTH-1:0] a_r, b_r, n_r;
    logic [WIDTH+1:0] acc;        // stays < 2N, so acc + B + N < 4N fits
    logic [WIDTH+1:0] sum_b, sum_n;
    logic [CNT_W-1:0] cnt;
    logic             run;

    always_comb begin
        sum_b = acc + (a_r[0] ? {2'b00, b_r} : '0);
        sum_n = sum_b;
        if (sum_b[0]) begin
            sum_n = sum_b + {2'b00, n_r};
        end
    end

    // WIDTH iterations, then one cycle presenting the reduced result
    assign done = run && (cnt == CNT_W'(MM_LAT - 1));
    assign V    = WIDTH'((acc >= {2'b00, n_r}) ? acc - {2'b00, n_r} : acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            n_r <= '0;
            acc <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            a_r <= A;
            b_r <= B;
            n_r <= N;
            acc <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (done) begin
                run <= 1'b0;
            end else begin
                acc <= sum_n >> 1;
                a_r <= a_r >> 1;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/rsa_modexp_lsb_param.sv
// LSB-first modular exponentiator, result = M^E mod N via radix-2 Montgomery.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of rsa_modexp_lsb_param_if
//              (start, M, E, N in; busy, done, err, result out)
// Flow: SCAN checks operands and finds the exponent length k, PRE converts
// M into the Montgomery domain (T = M*2^WIDTH mod N), EXP walks E[0..k-1]
// with two parallel mont_mul units, FIN presents the result for one cycle.
module rsa_modexp_lsb_param
    import rsa_modexp_lsb_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    rsa_modexp_lsb_param_if.slave  bus
);
    state_t state, state_next;

    logic [WIDTH-1:0] m_r, e_r, n_r, t_r, s_r, e_sh, res_r;
    logic [CNT_W-1:0] k_r, j_r, cnt_r, k_enc, j_inc;
    logic             exp_wait, err_r, done_r, busy_r;
    logic             scan_err, mm_start, mm_s_done, mm_t_done, mm_done;
    logic [WIDTH-1:0] mm_s_v, mm_t_v, s_next, t_dbl;
    logic [WIDTH:0]   t2;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = res_r;

    // k = MSB index of E plus 1; highest set bit wins
    always_comb begin
        k_enc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (e_r[i]) begin
                k_enc = CNT_W'(i + 1);
            end
        end
    end

    assign scan_err = ~n_r[0] | (m_r >= n_r);
    assign t2       = {t_r, 1'b0};
    assign t_dbl    = WIDTH'((t2 >= {1'b0, n_r}) ? t2 - {1'b0, n_r} : t2);
    assign mm_done  = mm_s_done & mm_t_done;
    assign s_next   = e_sh[0] ? mm_s_v : s_r;
    assign j_inc    = j_r + CNT_W'(1);

    mont_mul #(.WIDTH(WIDTH)) u_mm_s (
        .clk(clk), .rst(rst), .start(mm_start),
        .A(s_r), .B(t_r), .N(n_r), .done(mm_s_done), .V(mm_s_v)
    );

    mont_mul #(.WIDTH(WIDTH)) u_mm_t (
        .clk(clk), .rst(rst), .start(mm_start),
        .A(t_r), .B(t_r), .N(n_r), .done(mm_t_done), .V(mm_t_v)
    );

    always_comb begin
        state_next = state;
        mm_start   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_next = SCAN;
            SCAN: state_next = scan_err ? FIN : PRE;
            PRE:  if (cnt_r == CNT_W'(WIDTH)) state_next = (k_r == '0) ? FIN : EXP;
            EXP: begin
                if (!exp_wait) begin
                    mm_start = 1'b1;
                end else if (mm_done && (j_inc == k_r)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m_r      <= '0;
            e_r      <= '0;
            n_r      <= '0;
            t_r      <= '0;
            s_r      <= '0;
            e_sh     <= '0;
            res_r    <= '0;
            k_r      <= '0;
            j_r      <= '0;
            cnt_r    <= '0;
            exp_wait <= 1'b0;
            err_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state  <= state_next;
            // Outputs registered off the next state so done/busy line up with FIN
            done_r <= (state_next == FIN);
            busy_r <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_r   <= bus.M;
                        e_r   <= bus.E;
                        n_r   <= bus.N;
                        err_r <= 1'b0;
                        res_r <= '0;
                    end
                end
                SCAN: begin
                    err_r <= scan_err;
                    k_r   <= k_enc;
                    cnt_r <= '0;
                end
                PRE: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == '0) begin
                        // Load cycle; S = 1 mod N so N == 1 yields 0
                        t_r      <= m_r;
                        s_r      <= (n_r == WIDTH'(1)) ? '0 : WIDTH'(1);
                        e_sh     <= e_r;
                        j_r      <= '0;
                        exp_wait <= 1'b0;
                    end else begin
                        t_r <= t_dbl;
                    end
                    if (state_next == FIN) begin
                        res_r <= s_r;
                    end
                end
                EXP: begin
                    if (!exp_wait) begin
                        exp_wait <= 1'b1;
                    end else if (mm_done) begin
                        exp_wait <= 1'b0;
                        s_r      <= s_next;
                        t_r      <= mm_t_v;
                        e_sh     <= e_sh >> 1;
                        j_r      <= j_inc;
                        if (state_next == FIN) begin
                            res_r <= s_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
